// File: rtl/analog_probe_scanner.sv
// rtl/analog_probe_scanner.sv - round-robin multi-channel analog probe with sample averaging
module analog_probe_scanner #(
   parameter int NUM_CH = 8,
   parameter int DATA_W = 24,
   parameter int AVG_LOG2 = 2,
   parameter int TIMEOUT = 255,
   parameter logic signed [DATA_W-1:0] FALLBACK_V = DATA_W'(1234),
   parameter logic signed [DATA_W-1:0] FALLBACK_I = DATA_W'(123),
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [NUM_CH-1:0]        ch_enable,
   input  logic [NUM_CH-1:0]        ch_mode,
   output logic                     busy,
   output logic                     done,
   output logic                     be_req,
   output logic [CH_W-1:0]          be_ch,
   output logic                     be_mode,
   input  logic                     be_ack,
   input  logic                     be_valid,
   input  logic signed [DATA_W-1:0] be_data,
   input  logic [CH_W-1:0]          rd_ch,
   output logic signed [DATA_W-1:0] rd_data,
   output logic [NUM_CH-1:0]        err_flags
);

   localparam int ACC_W = DATA_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] SAMPLES = CNT_W'(1 << AVG_LOG2);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_REQ, S_ACCUM, S_FAIL, S_NEXT, S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [NUM_CH-1:0]        pending_q;
   logic [NUM_CH-1:0]        mode_lat_q;
   logic [CH_W-1:0]          cur_ch_q;
   logic                     cur_mode_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [WAIT_W-1:0]        wait_q;
   logic signed [DATA_W-1:0] results_q [2**CH_W];
   logic [NUM_CH-1:0]        err_q;

   logic [CH_W-1:0]          sel_ch;
   logic signed [ACC_W-1:0]  data_ext;
   logic signed [ACC_W-1:0]  acc_avg;
   logic                     sample_full;

   assign data_ext    = ACC_W'(be_data);
   assign acc_avg     = acc_q >>> AVG_LOG2;
   assign sample_full = (cnt_q == SAMPLES);
   assign be_ch       = cur_ch_q;
   assign be_mode     = cur_mode_q;
   assign rd_data     = results_q[rd_ch];
   assign err_flags   = err_q;

   // Lowest-index channel still waiting to be scanned
   always_comb begin
      sel_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (pending_q[i]) sel_ch = CH_W'(i);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and handshake/status outputs
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      be_req  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_SELECT;
         end
         S_SELECT: begin
            busy    = 1'b1;
            state_d = (pending_q == '0) ? S_DONE : S_REQ;
         end
         S_REQ: begin
            busy   = 1'b1;
            be_req = 1'b1;
            if (be_ack)                  state_d = be_valid ? S_ACCUM : S_FAIL;
            else if (wait_q == WAIT_LAST) state_d = S_FAIL;
         end
         S_ACCUM: begin
            busy    = 1'b1;
            state_d = sample_full ? S_NEXT : S_REQ;
         end
         S_FAIL: begin
            busy    = 1'b1;
            state_d = S_NEXT;
         end
         S_NEXT: begin
            busy    = 1'b1;
            state_d = (pending_q == '0) ? S_DONE : S_SELECT;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Channel bookkeeping, accumulation and result/error writes
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q  <= '0;
         mode_lat_q <= '0;
         cur_ch_q   <= '0;
         cur_mode_q <= 1'b0;
         acc_q      <= '0;
         cnt_q      <= '0;
         wait_q     <= '0;
         err_q      <= '0;
         for (int i = 0; i < 2**CH_W; i++) results_q[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  pending_q  <= ch_enable;
                  mode_lat_q <= ch_mode;
               end
            end
            S_SELECT: begin
               if (pending_q != '0) begin
                  cur_ch_q          <= sel_ch;
                  cur_mode_q        <= mode_lat_q[sel_ch];
                  pending_q[sel_ch] <= 1'b0;
               end
               acc_q  <= '0;
               cnt_q  <= '0;
               wait_q <= '0;
            end
            S_REQ: begin
               // The sample is folded in on the ack edge, so ACCUM only has to decide
               if (be_ack) begin
                  if (be_valid) begin
                     acc_q <= acc_q + data_ext;
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end
            S_ACCUM: begin
               if (sample_full) begin
                  results_q[cur_ch_q] <= acc_avg[DATA_W-1:0];
                  err_q[cur_ch_q]     <= 1'b0;
               end else begin
                  wait_q <= '0;
               end
            end
            S_FAIL: begin
               results_q[cur_ch_q] <= cur_mode_q ? FALLBACK_I : FALLBACK_V;
               err_q[cur_ch_q]     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_analog_probe_scanner.sv
// tb/tb_analog_probe_scanner.sv - scoreboard bench for analog_probe_scanner
module tb_analog_probe_scanner;

   localparam int NUM_CH = 8;
   localparam int NS = 4;
   localparam int BUDGET = 2000;

   logic clk = 1'b0;
   logic rst, start;
   logic [7:0] ch_enable, ch_mode;
   logic busy, done, be_req, be_mode;
   logic [2:0] be_ch;
   logic be_ack = 1'b0;
   logic be_valid = 1'b0;
   logic signed [23:0] be_data = '0;
   logic [2:0] rd_ch;
   logic signed [23:0] rd_data;
   logic [7:0] err_flags;

   typedef struct { bit valid; logic signed [23:0] data; } sample_t;
   typedef struct { int ch; logic signed [23:0] value; bit err; } exp_t;

   sample_t sample_q[$];
   exp_t    exp_q[$];

   int vectors = 0;
   int miscompares = 0;
   int ack_count[8] = '{default: 0};
   int req_cycles[8] = '{default: 0};
   bit mode_seen[8] = '{default: 1'b0};
   int done_pulses = 0;
   bit stall_en = 1'b0;
   int stall_ch = 0;
   logic signed [23:0] model_res[8] = '{default: '0};
   logic [7:0] model_err = '0;

   always #5 clk = ~clk;

   analog_probe_scanner dut (
      .clk(clk), .rst(rst), .start(start), .ch_enable(ch_enable), .ch_mode(ch_mode),
      .busy(busy), .done(done), .be_req(be_req), .be_ch(be_ch), .be_mode(be_mode),
      .be_ack(be_ack), .be_valid(be_valid), .be_data(be_data),
      .rd_ch(rd_ch), .rd_data(rd_data), .err_flags(err_flags)
   );

   // Backend model: acks in the same cycle as the request unless the channel is stalled
   always @(negedge clk) begin : responder
      sample_t s;
      if (done) done_pulses++;
      be_ack = 1'b0; be_valid = 1'b0; be_data = '0;
      if (be_req) begin
         req_cycles[be_ch]++;
         mode_seen[be_ch] = be_mode;
         if (!(stall_en && int'(be_ch) == stall_ch)) begin
            if (sample_q.size() > 0) s = sample_q.pop_front();
            else begin s.valid = 1'b0; s.data = '0; end
            be_ack = 1'b1; be_valid = s.valid; be_data = s.data;
            ack_count[be_ch]++;
         end
      end
   end

   task automatic add_valid_ch(input int ch, input logic signed [23:0] s0, s1, s2, s3);
      longint sum, q;
      exp_t e;
      sample_q.push_back('{1'b1, s0}); sample_q.push_back('{1'b1, s1});
      sample_q.push_back('{1'b1, s2}); sample_q.push_back('{1'b1, s3});
      sum = longint'(s0) + longint'(s1) + longint'(s2) + longint'(s3);
      q = sum / NS;
      if ((sum % NS) != 0 && sum < 0) q = q - 1;
      model_res[ch] = 24'(q);
      model_err[ch] = 1'b0;
      e.ch = ch; e.value = model_res[ch]; e.err = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic add_fail_ch(input int ch, input bit mode, input bit send_invalid);
      exp_t e;
      if (send_invalid) sample_q.push_back('{1'b0, 24'sd0});
      model_res[ch] = mode ? 24'sd123 : 24'sd1234;
      model_err[ch] = 1'b1;
      e.ch = ch; e.value = model_res[ch]; e.err = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic expect_keep(input int ch);
      exp_t e;
      e.ch = ch; e.value = model_res[ch]; e.err = model_err[ch];
      exp_q.push_back(e);
   endtask

   // Starts one scan and returns the number of clock edges until done is seen
   task automatic do_scan(input logic [7:0] en, input logic [7:0] md, output int edges);
      @(negedge clk);
      ch_enable = en; ch_mode = md; start = 1'b1; edges = 0;
      do begin
         @(posedge clk); edges++;
         @(negedge clk); start = 1'b0;
      end while (!done && edges < BUDGET);
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; ch_enable = '0; ch_mode = '0; rd_ch = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({busy, done, be_req, be_ch, be_mode} !== 7'b0 || err_flags !== 8'h00) begin
         $display("FAIL reset_outputs: got busy=%b done=%b req=%b ch=%0d mode=%b err=%h, required all 0",
                  busy, done, be_req, be_ch, be_mode, err_flags);
         miscompares++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         rd_ch = 3'(i); #1;
         vectors++;
         if (rd_data !== 24'sd0) begin
            $display("FAIL reset_result ch%0d: got %0d, required 0", i, rd_data);
            miscompares++;
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_average;
      int edges, a0, a2, p0;
      exp_t e;
      a0 = ack_count[0]; a2 = ack_count[2]; p0 = done_pulses;
      add_valid_ch(0, 24'sd100, 24'sd101, 24'sd102, 24'sd103);
      add_valid_ch(2, 24'sd100, 24'sd101, 24'sd102, 24'sd103);
      do_scan(8'h05, 8'h00, edges);
      vectors++;
      // Two channels with immediate ack: 2 + 2*(2 + 2*4) = 22 cycles, done on the 21st edge
      if (edges !== 21) begin
         $display("FAIL avg_latency: done after %0d edges, required 21", edges);
         miscompares++;
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (done_pulses - p0 !== 1) begin
         $display("FAIL avg_done_pulses: got %0d, required 1", done_pulses - p0);
         miscompares++;
      end
      vectors++;
      if (ack_count[0] - a0 !== 4 || ack_count[2] - a2 !== 4) begin
         $display("FAIL avg_requests: ch0 %0d ch2 %0d, required 4 each", ack_count[0] - a0, ack_count[2] - a2);
         miscompares++;
      end
      vectors++;
      if (err_flags !== model_err) begin
         $display("FAIL avg_err_flags: got %h, required %h", err_flags, model_err);
         miscompares++;
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         rd_ch = 3'(e.ch); #1;
         vectors++;
         if (rd_data !== e.value || err_flags[e.ch] !== e.err) begin
            $display("FAIL avg_result ch%0d: got %0d err %b, required %0d err %b", e.ch, rd_data, err_flags[e.ch], e.value, e.err);
            miscompares++;
         end
      end
   endtask

   task automatic test_invalid;
      int edges, a2;
      exp_t e;
      a2 = ack_count[2];
      expect_keep(0);
      add_fail_ch(2, 1'b1, 1'b1);
      do_scan(8'h04, 8'h04, edges);
      repeat (2) @(negedge clk);
      vectors++;
      if (edges >= BUDGET || ack_count[2] - a2 !== 1 || mode_seen[2] !== 1'b1) begin
         $display("FAIL invalid_requests: edges %0d reqs %0d mode %b, required <%0d, 1, 1", edges, ack_count[2] - a2, mode_seen[2], BUDGET);
         miscompares++;
      end
      vectors++;
      if (err_flags !== model_err) begin
         $display("FAIL invalid_err_flags: got %h, required %h", err_flags, model_err);
         miscompares++;
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         rd_ch = 3'(e.ch); #1;
         vectors++;
         if (rd_data !== e.value || err_flags[e.ch] !== e.err) begin
            $display("FAIL invalid_result ch%0d: got %0d err %b, required %0d err %b", e.ch, rd_data, err_flags[e.ch], e.value, e.err);
            miscompares++;
         end
      end
   endtask

   task automatic test_timeout;
      int edges, r1, a1, a3;
      exp_t e;
      r1 = req_cycles[1]; a1 = ack_count[1]; a3 = ack_count[3];
      stall_en = 1'b1; stall_ch = 1;
      add_fail_ch(1, 1'b0, 1'b0);
      add_valid_ch(3, 24'sd8, 24'sd8, 24'sd8, 24'sd9);
      do_scan(8'h0A, 8'h00, edges);
      stall_en = 1'b0;
      vectors++;
      if (edges >= BUDGET || req_cycles[1] - r1 !== 255 || ack_count[1] - a1 !== 0) begin
         $display("FAIL timeout_req_cycles: edges %0d req cycles %0d acks %0d, required <%0d, 255, 0", edges, req_cycles[1] - r1, ack_count[1] - a1, BUDGET);
         miscompares++;
      end
      vectors++;
      if (ack_count[3] - a3 !== 4 || err_flags !== model_err) begin
         $display("FAIL timeout_continue: ch3 reqs %0d err %h, required 4, %h", ack_count[3] - a3, err_flags, model_err);
         miscompares++;
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         rd_ch = 3'(e.ch); #1;
         vectors++;
         if (rd_data !== e.value || err_flags[e.ch] !== e.err) begin
            $display("FAIL timeout_result ch%0d: got %0d err %b, required %0d err %b", e.ch, rd_data, err_flags[e.ch], e.value, e.err);
            miscompares++;
         end
      end
   endtask

   task automatic test_negative;
      int edges;
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: add_valid_ch(0, -24'sd1, -24'sd2, -24'sd2, -24'sd2);
            1: add_valid_ch(0, 24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF);
            default: add_valid_ch(0, 24'sh800000, 24'sh800000, 24'sh800000, 24'sh800000);
         endcase
         do_scan(8'h01, 8'h00, edges);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rd_ch = 3'(e.ch); #1;
            vectors++;
            if (edges >= BUDGET || rd_data !== e.value || err_flags[e.ch] !== e.err) begin
               $display("FAIL signed_result pass%0d: got %0d err %b (edges %0d), required %0d err %b", k, rd_data, err_flags[e.ch], edges, e.value, e.err);
               miscompares++;
            end
         end
      end
   endtask

   task automatic test_start_busy;
      int edges, p0, tot0, tot1, wait_cnt;
      exp_t e;
      p0 = done_pulses;
      tot0 = 0; foreach (ack_count[i]) tot0 += req_cycles[i];
      add_valid_ch(0, 24'sd10, 24'sd20, 24'sd30, 24'sd40);
      @(negedge clk);
      ch_enable = 8'h01; ch_mode = 8'h00; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      ch_enable = 8'hFF; ch_mode = 8'hFF; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_cnt = 0;
      while (!done && wait_cnt < BUDGET) begin @(negedge clk); wait_cnt++; end
      repeat (30) @(negedge clk);
      tot1 = 0; foreach (ack_count[i]) tot1 += req_cycles[i];
      vectors++;
      if (done_pulses - p0 !== 1 || tot1 - tot0 !== 4) begin
         $display("FAIL busy_start_ignored: done pulses %0d requests %0d, required 1, 4", done_pulses - p0, tot1 - tot0);
         miscompares++;
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         rd_ch = 3'(e.ch); #1;
         vectors++;
         if (rd_data !== e.value) begin
            $display("FAIL busy_result ch%0d: got %0d, required %0d", e.ch, rd_data, e.value);
            miscompares++;
         end
      end
      do_scan(8'h00, 8'h00, edges);
      tot0 = 0; foreach (ack_count[i]) tot0 += req_cycles[i];
      vectors++;
      if (edges !== 2 || tot0 !== tot1) begin
         $display("FAIL empty_scan: done after %0d edges with %0d requests, required 2 and 0", edges, tot0 - tot1);
         miscompares++;
      end
   endtask

   task automatic test_reset_mid;
      int wait_cnt;
      stall_en = 1'b1; stall_ch = 0;
      @(negedge clk);
      ch_enable = 8'h01; ch_mode = 8'h00; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_cnt = 0;
      while (!be_req && wait_cnt < 20) begin @(negedge clk); wait_cnt++; end
      repeat (5) @(negedge clk);
      vectors++;
      if (be_req !== 1'b1) begin
         $display("FAIL abort_setup: be_req %b, required 1", be_req);
         miscompares++;
      end
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      vectors++;
      if (be_req !== 1'b0 || busy !== 1'b0 || err_flags !== 8'h00) begin
         $display("FAIL abort_outputs: req %b busy %b err %h, required 0 0 00", be_req, busy, err_flags);
         miscompares++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         rd_ch = 3'(i); #1;
         vectors++;
         if (rd_data !== 24'sd0) begin
            $display("FAIL abort_result ch%0d: got %0d, required 0", i, rd_data);
            miscompares++;
         end
         model_res[i] = '0;
      end
      model_err = '0;
      sample_q.delete();
      rst = 1'b0; start = 1'b0; stall_en = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || be_req !== 1'b0) begin
         $display("FAIL start_with_rst: busy %b req %b, required 0 0", busy, be_req);
         miscompares++;
      end
   endtask

   task automatic test_back_to_back;
      int edges, n_en;
      logic [7:0] en, md;
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         en = 8'($urandom_range(1, 255)); md = 8'($urandom); n_en = 0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (en[ch]) begin
               n_en++;
               add_valid_ch(ch, 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
            end else begin
               expect_keep(ch);
            end
         end
         do_scan(en, md, edges);
         vectors++;
         if (edges !== 2 + n_en * (2 + 2 * NS) - 1) begin
            $display("FAIL b2b_latency: en %h done after %0d edges, required %0d", en, edges, 2 + n_en * (2 + 2 * NS) - 1);
            miscompares++;
         end
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rd_ch = 3'(e.ch); #1;
            vectors++;
            if (rd_data !== e.value || err_flags[e.ch] !== e.err) begin
               $display("FAIL b2b_result ch%0d: got %0d err %b, required %0d err %b", e.ch, rd_data, err_flags[e.ch], e.value, e.err);
               miscompares++;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_average();
      test_invalid();
      test_timeout();
      test_negative();
      test_start_busy();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
